// File: rtl/fnd_stopwatch_ctrl.sv
// Run/pause/clear stopwatch controller for the 4-digit FND count path.
// Optional lap hold on the displayed value: define FND_STOPWATCH_LAP_EN.
module fnd_stopwatch_ctrl #(
    parameter int unsigned TICK_DIV  = 10_000_000,
    parameter int unsigned MAX_COUNT = 9999
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_btnRunStop,
    input  logic        i_btnClear,
`ifdef FND_STOPWATCH_LAP_EN
    input  logic        i_btnLap,
`endif
    output logic [13:0] o_value,
    output logic        o_running,
    output logic        o_tick,
    output logic        o_wrap
);

    localparam int unsigned VAL_W = 14;
    localparam int unsigned PRE_W = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [VAL_W-1:0] VAL_MAX  = VAL_W'(MAX_COUNT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        CLEAR = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             prev_run;
    logic             prev_clr;
    logic             run_edge_c;
    logic             clr_edge_c;
    logic [PRE_W-1:0] presc;
    logic [PRE_W-1:0] presc_next;
    logic [VAL_W-1:0] count;
    logic [VAL_W-1:0] count_next;
    logic             tick_next;
    logic             wrap_next;
    logic [VAL_W-1:0] disp_next;

    assign run_edge_c = i_btnRunStop & ~prev_run;
    assign clr_edge_c = i_btnClear & ~prev_clr;

`ifdef FND_STOPWATCH_LAP_EN
    logic             prev_lap;
    logic             lap_edge_c;
    logic             lap_hold;
    logic             lap_hold_next;
    logic [VAL_W-1:0] lap_val;
    logic [VAL_W-1:0] lap_val_next;

    assign lap_edge_c = i_btnLap & ~prev_lap;

    // Lap toggles only while running; any exit from RUN drops the hold.
    always_comb begin
        lap_hold_next = lap_hold;
        lap_val_next  = lap_val;
        if (state == RUN && lap_edge_c) begin
            lap_hold_next = ~lap_hold;
            lap_val_next  = count;
        end
        if (state_next != RUN) begin
            lap_hold_next = 1'b0;
        end
        disp_next = lap_hold_next ? lap_val_next : count_next;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            prev_lap <= i_btnLap;
            lap_hold <= 1'b0;
            lap_val  <= '0;
        end else begin
            prev_lap <= i_btnLap;
            lap_hold <= lap_hold_next;
            lap_val  <= lap_val_next;
        end
    end
`else
    assign disp_next = count_next;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and count datapath; a clear edge outranks everything.
    always_comb begin
        state_next = state;
        presc_next = presc;
        count_next = count;
        tick_next  = 1'b0;
        wrap_next  = 1'b0;
        case (state)
            IDLE: begin
                if (clr_edge_c) begin
                    state_next = CLEAR;
                end else if (run_edge_c) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (clr_edge_c) begin
                    state_next = CLEAR;
                    presc_next = '0;
                    count_next = '0;
                end else begin
                    if (presc == PRE_LAST) begin
                        presc_next = '0;
                        tick_next  = 1'b1;
                        if (count == VAL_MAX) begin
                            count_next = '0;
                            wrap_next  = 1'b1;
                        end else begin
                            count_next = count + VAL_W'(1);
                        end
                    end else begin
                        presc_next = presc + PRE_W'(1);
                    end
                    if (run_edge_c) begin
                        state_next = PAUSE;
                    end
                end
            end
            PAUSE: begin
                if (clr_edge_c) begin
                    state_next = CLEAR;
                    presc_next = '0;
                    count_next = '0;
                end else if (run_edge_c) begin
                    state_next = RUN;
                end
            end
            CLEAR: begin
                state_next = IDLE;
                presc_next = '0;
                count_next = '0;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Button history loads the live level in reset so a held button never fires.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            prev_run  <= i_btnRunStop;
            prev_clr  <= i_btnClear;
            presc     <= '0;
            count     <= '0;
            o_value   <= '0;
            o_running <= 1'b0;
            o_tick    <= 1'b0;
            o_wrap    <= 1'b0;
        end else begin
            prev_run  <= i_btnRunStop;
            prev_clr  <= i_btnClear;
            presc     <= presc_next;
            count     <= count_next;
            o_value   <= disp_next;
            o_running <= (state == RUN);
            o_tick    <= tick_next;
            o_wrap    <= wrap_next;
        end
    end

endmodule

// File: tb/tb_fnd_stopwatch_ctrl.sv
// Bench for fnd_stopwatch_ctrl: two instances (MAX_COUNT 9999 and 12) against a tick-count model.
module tb_fnd_stopwatch_ctrl;

    localparam int TD    = 4;
    localparam int MAX_A = 9999;
    localparam int MAX_B = 12;
`ifdef FND_STOPWATCH_LAP_EN
    localparam bit LAP_ON = 1'b1;
`else
    localparam bit LAP_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_run = 1'b0;
    logic        btn_clr = 1'b0;
    logic        btn_lap = 1'b0;
    logic [13:0] val_a, val_b;
    logic        run_a, run_b, tick_a, tick_b, wrap_a, wrap_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fnd_stopwatch_ctrl #(.TICK_DIV(TD), .MAX_COUNT(MAX_A)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_btnRunStop(btn_run), .i_btnClear(btn_clr),
`ifdef FND_STOPWATCH_LAP_EN
        .i_btnLap(btn_lap),
`endif
        .o_value(val_a), .o_running(run_a), .o_tick(tick_a), .o_wrap(wrap_a)
    );

    fnd_stopwatch_ctrl #(.TICK_DIV(TD), .MAX_COUNT(MAX_B)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_btnRunStop(btn_run), .i_btnClear(btn_clr),
`ifdef FND_STOPWATCH_LAP_EN
        .i_btnLap(btn_lap),
`endif
        .o_value(val_b), .o_running(run_b), .o_tick(tick_b), .o_wrap(wrap_b)
    );

    // Model: mode 0 idle, 1 run, 2 pause, 3 clear; count = total ticks mod (max+1).
    int m_mode [2] = '{0, 0};
    int m_phase[2] = '{0, 0};
    int m_ticks[2] = '{0, 0};
    int m_lapv [2] = '{0, 0};
    bit m_lap  [2] = '{0, 0};
    bit m_run  [2] = '{0, 0};
    bit m_tick [2] = '{0, 0};
    bit m_wrap [2] = '{0, 0};
    bit m_pr = 1'b0, m_pc = 1'b0, m_pl = 1'b0;
    bit e_run, e_clr, e_lap;
    int old_v;

    function automatic int m_max(int i);
        return (i == 0) ? MAX_A : MAX_B;
    endfunction

    function automatic int m_disp(int i);
        return m_lap[i] ? m_lapv[i] : (m_ticks[i] % (m_max(i) + 1));
    endfunction

    always @(posedge clk) begin
        e_run = btn_run && !m_pr;
        e_clr = btn_clr && !m_pc;
        e_lap = LAP_ON && btn_lap && !m_pl;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_mode[i] = 0; m_phase[i] = 0; m_ticks[i] = 0; m_lap[i] = 0;
                m_run[i] = 0; m_tick[i] = 0; m_wrap[i] = 0;
            end else begin
                m_run[i]  = (m_mode[i] == 1);
                m_tick[i] = 0;
                m_wrap[i] = 0;
                if (m_mode[i] == 3) begin
                    m_mode[i] = 0; m_ticks[i] = 0; m_phase[i] = 0;
                end else if (e_clr) begin
                    m_mode[i] = 3; m_ticks[i] = 0; m_phase[i] = 0; m_lap[i] = 0;
                end else if (m_mode[i] == 1) begin
                    old_v = m_ticks[i] % (m_max(i) + 1);
                    m_phase[i]++;
                    if (m_phase[i] == TD) begin
                        m_phase[i] = 0;
                        m_ticks[i]++;
                        m_tick[i] = 1;
                        m_wrap[i] = (m_ticks[i] % (m_max(i) + 1)) == 0;
                    end
                    if (e_lap) begin
                        m_lap[i]  = !m_lap[i];
                        m_lapv[i] = old_v;
                    end
                    if (e_run) begin
                        m_mode[i] = 2; m_lap[i] = 0;
                    end
                end else if (e_run) begin
                    m_mode[i] = 1;
                end
            end
        end
        m_pr = btn_run;
        m_pc = btn_clr;
        m_pl = btn_lap;
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (val_a !== 14'd0) $display("FAIL reset_value got=%0d exp=0", val_a); else n_pass++;
        n_checks++; if (run_a !== 1'b0) $display("FAIL reset_running got=%b exp=0", run_a); else n_pass++;
        n_checks++; if (tick_a !== 1'b0 || wrap_a !== 1'b0) $display("FAIL reset_pulses got=%b%b exp=00", tick_a, wrap_a); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (run_b !== 1'b0 || val_b !== 14'd0) $display("FAIL post_reset_b got=%b/%0d exp=0/0", run_b, val_b); else n_pass++;
    endtask

    task automatic test_run_start();
        btn_run = 1'b1;
        @(negedge clk);
        btn_run = 1'b0;
        n_checks++; if (run_a !== 1'b0) $display("FAIL run_lat1 got=%b exp=0", run_a); else n_pass++;
        @(negedge clk);
        n_checks++; if (run_a !== 1'b1) $display("FAIL run_lat2 got=%b exp=1", run_a); else n_pass++;
        for (int k = 3; k <= 13; k++) begin
            @(negedge clk);
            n_checks++;
            if (tick_a !== 1'((k >= 5) && ((k - 5) % 4 == 0)))
                $display("FAIL tick_period cycle=%0d got=%b", k, tick_a);
            else n_pass++;
        end
        n_checks++; if (val_a !== 14'd3) $display("FAIL value_after_12 got=%0d exp=3", val_a); else n_pass++;
    endtask

    task automatic test_pause_resume();
        for (int k = 0; k < 40 && val_a != 14'd5; k++) @(negedge clk);
        n_checks++; if (val_a !== 14'd5) $display("FAIL reach5 got=%0d exp=5", val_a); else n_pass++;
        repeat (2) @(negedge clk);
        btn_run = 1'b1;
        @(negedge clk);
        btn_run = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n_checks++;
            if (val_a !== 14'd5 || tick_a !== 1'b0) $display("FAIL pause_hold k=%0d got=%0d/%b exp=5/0", k, val_a, tick_a);
            else n_pass++;
        end
        n_checks++; if (run_a !== 1'b0) $display("FAIL pause_running got=%b exp=0", run_a); else n_pass++;
        btn_run = 1'b1;
        @(negedge clk);
        btn_run = 1'b0;
        n_checks++; if (tick_a !== 1'b0 || val_a !== 14'd5) $display("FAIL resume_c1 got=%b/%0d exp=0/5", tick_a, val_a); else n_pass++;
        @(negedge clk);
        n_checks++; if (tick_a !== 1'b1 || val_a !== 14'd6) $display("FAIL resume_partial got=%b/%0d exp=1/6", tick_a, val_a); else n_pass++;
    endtask

    task automatic test_clear_priority();
        for (int k = 0; k < 40 && val_a != 14'd7; k++) @(negedge clk);
        n_checks++; if (val_a !== 14'd7) $display("FAIL reach7 got=%0d exp=7", val_a); else n_pass++;
        btn_run = 1'b1;
        btn_clr = 1'b1;
        @(negedge clk);
        btn_run = 1'b0;
        btn_clr = 1'b0;
        n_checks++; if (val_a !== 14'd0 || tick_a !== 1'b0) $display("FAIL clear_value got=%0d/%b exp=0/0", val_a, tick_a); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (run_a !== 1'b0 || val_a !== 14'd0) $display("FAIL clear_idle k=%0d got=%b/%0d exp=0/0", k, run_a, val_a);
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        int prev_v;
        int nw;
        nw = 0;
        btn_run = 1'b1;
        @(negedge clk);
        btn_run = 1'b0;
        for (int k = 0; k < 80 && val_b != 14'd12; k++) @(negedge clk);
        n_checks++; if (val_b !== 14'd12) $display("FAIL reach12 got=%0d exp=12", val_b); else n_pass++;
        for (int k = 0; k < 40; k++) begin
            prev_v = int'(val_b);
            @(negedge clk);
            n_checks++;
            if (wrap_b !== 1'(m_wrap[1]) || val_b !== 14'(m_disp(1)))
                $display("FAIL wrap_model k=%0d got=%b/%0d exp=%b/%0d", k, wrap_b, val_b, m_wrap[1], m_disp(1));
            else n_pass++;
            if (wrap_b === 1'b1) begin
                nw++;
                n_checks++;
                if (prev_v != 12 || val_b !== 14'd0) $display("FAIL wrap_edge got=%0d->%0d exp=12->0", prev_v, val_b);
                else n_pass++;
            end
        end
        n_checks++; if (nw != 1) $display("FAIL wrap_count got=%0d exp=1", nw); else n_pass++;
        n_checks++; if (wrap_a !== 1'b0) $display("FAIL wrap_a got=%b exp=0", wrap_a); else n_pass++;
    endtask

    task automatic test_held_reset();
        btn_run = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if (run_a !== 1'b0 || val_a !== 14'd0) $display("FAIL held_reset k=%0d got=%b/%0d exp=0/0", k, run_a, val_a);
            else n_pass++;
        end
        btn_run = 1'b0;
        @(negedge clk);
        btn_run = 1'b1;
        @(negedge clk);
        btn_run = 1'b0;
        @(negedge clk);
        n_checks++; if (run_a !== 1'b1) $display("FAIL held_then_press got=%b exp=1", run_a); else n_pass++;
    endtask

    task automatic test_random();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            rst     = ($urandom % 300) == 0;
            btn_run = (($urandom % 6) == 0) ? ~btn_run : btn_run;
            btn_clr = (($urandom % 40) == 0) ? ~btn_clr : btn_clr;
            btn_lap = (($urandom % 10) == 0) ? ~btn_lap : btn_lap;
            @(negedge clk);
            n_checks++;
            if (val_a !== 14'(m_disp(0)) || run_a !== 1'(m_run[0]) || tick_a !== 1'(m_tick[0]) || wrap_a !== 1'(m_wrap[0]))
                $display("FAIL rand_a k=%0d got=%0d/%b/%b/%b exp=%0d/%b/%b/%b", k, val_a, run_a, tick_a, wrap_a,
                         m_disp(0), m_run[0], m_tick[0], m_wrap[0]);
            else n_pass++;
            n_checks++;
            if (val_b !== 14'(m_disp(1)) || run_b !== 1'(m_run[1]) || tick_b !== 1'(m_tick[1]) || wrap_b !== 1'(m_wrap[1]))
                $display("FAIL rand_b k=%0d got=%0d/%b/%b/%b exp=%0d/%b/%b/%b", k, val_b, run_b, tick_b, wrap_b,
                         m_disp(1), m_run[1], m_tick[1], m_wrap[1]);
            else n_pass++;
        end
        rst = 1'b0;
        btn_run = 1'b0;
        btn_clr = 1'b0;
        btn_lap = 1'b0;
    endtask

`ifdef FND_STOPWATCH_LAP_EN
    task automatic test_lap();
        int nt;
        nt = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        btn_run = 1'b1;
        @(negedge clk);
        btn_run = 1'b0;
        for (int k = 0; k < 60 && val_a != 14'd9; k++) @(negedge clk);
        n_checks++; if (val_a !== 14'd9) $display("FAIL reach9 got=%0d exp=9", val_a); else n_pass++;
        btn_lap = 1'b1;
        @(negedge clk);
        btn_lap = 1'b0;
        for (int k = 0; k < 60 && nt < 8; k++) begin
            @(negedge clk);
            if (tick_a === 1'b1) nt++;
            n_checks++;
            if (val_a !== 14'd9) $display("FAIL lap_frozen k=%0d got=%0d exp=9", k, val_a); else n_pass++;
        end
        n_checks++; if (nt != 8) $display("FAIL lap_ticks got=%0d exp=8", nt); else n_pass++;
        btn_lap = 1'b1;
        @(negedge clk);
        btn_lap = 1'b0;
        n_checks++; if (val_a !== 14'd17) $display("FAIL lap_release got=%0d exp=17", val_a); else n_pass++;
        n_checks++; if (val_b !== 14'(m_disp(1))) $display("FAIL lap_b got=%0d exp=%0d", val_b, m_disp(1)); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_run_start();
        test_pause_resume();
        test_clear_priority();
        test_wrap();
        test_held_reset();
        test_random();
`ifdef FND_STOPWATCH_LAP_EN
        test_lap();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fnd_stopwatch_ctrl.md
Name: fnd_stopwatch_ctrl

Overview:
- Run/pause/clear controller that sequences the 4-digit FND count datapath.
- Turns two pushbutton levels into edge-triggered commands with a 4-state FSM.
- Generates the count-enable tick from the system clock and holds the 14-bit count value (0..MAX_COUNT) that feeds the digit splitter and the FND decoder chain.
- Replaces the free-running 10 Hz counter path with a controllable stopwatch.

Parameters:
- TICK_DIV, 10_000_000, system-clock cycles per count increment (100 MHz -> 10 Hz); must be >= 2.
- MAX_COUNT, 9999, last value before wrap to 0; must be <= 16383.

Ports:
- i_clk  input  1  system clock; all logic on the rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_btnRunStop  input  1  debounced level; each rising edge toggles run/pause.
- i_btnClear  input  1  debounced level; a rising edge zeroes the count and stops.
- o_value  output  14  count value to the digit splitter.
- o_running  output  1  high while in state RUN.
- o_tick  output  1  one-cycle pulse on each cycle where the count advances.
- o_wrap  output  1  one-cycle pulse when the count wraps MAX_COUNT -> 0.

Behaviour:
- Reset (sync, i_reset=1 at a clock edge):
  - state=IDLE, o_value=0, prescaler=0, o_running=0, o_tick=0, o_wrap=0.
  - Button history registers are loaded with the current button levels, so a button held through reset does not fire.
- Edge detect:
  - runEdge = i_btnRunStop & ~prev; clrEdge = i_btnClear & ~prev.
  - One history register per button, updated every cycle.
  - A command takes effect on the edge after the rising level is sampled: one-cycle command latency.
- States and transitions. clrEdge has priority over runEdge in every state.
  - IDLE: count is 0.
    - runEdge -> RUN.
    - clrEdge -> CLEAR.
  - RUN:
    - Prescaler increments each cycle. At TICK_DIV-1 it returns to 0 and o_value advances in the same edge.
    - runEdge -> PAUSE.
    - clrEdge -> CLEAR.
  - PAUSE:
    - Prescaler and o_value are held. Resume continues the partial tick period; the prescaler is not restarted.
    - runEdge -> RUN.
    - clrEdge -> CLEAR.
  - CLEAR: one cycle only.
    - o_value=0, prescaler=0.
    - Unconditional -> IDLE.
    - Edges arriving during CLEAR are ignored.
- Tick cycle and runEdge in the same cycle in RUN: the increment is still applied, then the FSM goes to PAUSE.
- Tick cycle and clrEdge in the same cycle: the clear wins; o_value=0 and no o_tick.
- Count arithmetic:
  - o_value < MAX_COUNT: o_value+1.
  - o_value == MAX_COUNT: o_value=0 and o_wrap=1 for that cycle.
  - o_value never exceeds MAX_COUNT.
- o_tick and o_wrap are registered and asserted for exactly one cycle, aligned with the cycle o_value shows the new count.
- o_running = (state==RUN), registered.
- Reset mid-RUN: all state is lost on the next edge; no tick is issued in the reset cycle.

Optional Feature:
- Macro: FND_STOPWATCH_LAP_EN.
- When defined:
  - Adds input i_btnLap (1 bit, debounced level), with its own edge detect.
  - A rising edge in RUN toggles a lap hold. While held, o_value is frozen at the captured count and the internal count keeps advancing. o_tick and o_wrap follow the internal count.
  - Second lap edge: o_value shows the live count again from the next cycle.
  - Lap hold is released by clrEdge, by reset, or on leaving RUN. In PAUSE, o_value shows the live count.
  - Lap edges in IDLE, PAUSE or CLEAR are ignored.
- When not defined: no i_btnLap port, and o_value is always the live count.

Test Plan:
- TICK_DIV=4, MAX_COUNT=9999; reset, then a runEdge.
  - o_running=1 after 2 cycles.
  - o_tick every 4th cycle.
  - o_value reaches 3 after 12 running cycles.
- RUN at o_value=5, then runEdge, 20 idle cycles, runEdge.
  - o_value holds 5 during PAUSE.
  - The next tick comes after the remaining prescaler cycles, not a full 4.
- MAX_COUNT=12 in RUN.
  - Sequence runs ...11, 12, 0.
  - o_wrap=1 only in the cycle o_value becomes 0.
- clrEdge and runEdge in the same cycle while in RUN at o_value=7.
  - Next cycle: state CLEAR, o_value=0.
  - Then IDLE with o_running=0.
- i_btnRunStop held high through reset release: no transition. A later release then press -> RUN.
- With FND_STOPWATCH_LAP_EN defined: lap edge at o_value=9, run 8 more ticks.
  - o_value stays 9 while the internal count reaches 17.
  - A second lap edge makes o_value show 17.
